vram_write_queue_m: RTL and testbench



---
 rtl/vram_write_queue_m.sv | 146 ++++++++++++++
 tb/tb_vram_write_queue_m.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vram_write_queue_m.sv
// CPU-to-GPU VRAM write queue: buffers writes in a FIFO and replays them only during vblank.
// Optional macro VRAM_WQ_COALESCE_EN merges a write into the still-queued tail entry on address match.

`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 16
`endif

module vram_write_queue_m #(
  parameter int unsigned ADDR_WIDTH = `VRAM_ADDR_WIDTH,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                      clk_12_5875,
  input  logic                      rst,
  input  logic                      cpu_wr_valid,
  output logic                      cpu_wr_ready,
  input  logic [ADDR_WIDTH-1:0]     cpu_addr,
  input  logic [7:0]                cpu_data,
  input  logic                      vblank,
  output logic                      gpu_wr_en,
  output logic [ADDR_WIDTH-1:0]     gpu_address,
  output logic [7:0]                gpu_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {StIdle, StDrain} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  gpu_wr_en_q, gpu_wr_en_d;
  logic [ADDR_WIDTH-1:0] gpu_address_q, gpu_address_d;
  logic [7:0]            gpu_data_q, gpu_data_d;

  logic [ADDR_WIDTH-1:0] mem_addr_q [DEPTH];
  logic [7:0]            mem_data_q [DEPTH];

  logic                  ready;
  logic                  push;
  logic                  pop;
  logic                  coalesce;
  logic                  alloc;
  logic [PW-1:0]         mem_waddr;

  assign ready = (count_q != CW'(DEPTH));
  assign push  = cpu_wr_valid && ready;
  // Pop decision uses registered count, so a freshly enqueued entry waits one cycle.
  assign pop   = (state_q == StDrain) && vblank && (count_q != '0);

`ifdef VRAM_WQ_COALESCE_EN
  logic [PW-1:0] last_ptr;
  assign last_ptr = wr_ptr_q - PW'(1);
  // The tail is still queued whenever the FIFO is non-empty; skip it if it leaves this cycle.
  assign coalesce = push && (count_q != '0) && (mem_addr_q[last_ptr] == cpu_addr) &&
                    !(pop && (count_q == CW'(1)));
  assign mem_waddr = coalesce ? last_ptr : wr_ptr_q;
`else
  assign coalesce  = 1'b0;
  assign mem_waddr = wr_ptr_q;
`endif

  assign alloc = push && !coalesce;

  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    overflow_d    = overflow_q | (cpu_wr_valid && !ready);
    gpu_wr_en_d   = pop;
    gpu_address_d = gpu_address_q;
    gpu_data_d    = gpu_data_q;

    if (alloc) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d      = rd_ptr_q + PW'(1);
      gpu_address_d = mem_addr_q[rd_ptr_q];
      gpu_data_d    = mem_data_q[rd_ptr_q];
    end

    unique case ({alloc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      StIdle: begin
        if (vblank && (count_q != '0)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!vblank || (pop && !alloc && (count_q == CW'(1)))) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_12_5875 or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      gpu_wr_en_q   <= 1'b0;
      gpu_address_q <= '0;
      gpu_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      gpu_wr_en_q   <= gpu_wr_en_d;
      gpu_address_q <= gpu_address_d;
      gpu_data_q    <= gpu_data_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk_12_5875) begin
    if (push) begin
      mem_addr_q[mem_waddr] <= cpu_addr;
      mem_data_q[mem_waddr] <= cpu_data;
    end
  end

  assign cpu_wr_ready = ready;
  assign gpu_wr_en    = gpu_wr_en_q;
  assign gpu_address  = gpu_address_q;
  assign gpu_data     = gpu_data_q;
  assign count        = count_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_vram_write_queue_m.sv
// Bench for vram_write_queue_m: directed scenarios plus random traffic against a queue-based model.

module tb_vram_write_queue_m;

  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef VRAM_WQ_COALESCE_EN
  localparam int ExpCoal = 1;
`else
  localparam int ExpCoal = 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic          vblank;
  logic [AW-1:0] addr;
  logic [7:0]    data;
  logic          cpu_wr_ready;
  logic          gpu_wr_en;
  logic [AW-1:0] gpu_address;
  logic [7:0]    gpu_data;
  logic [CW-1:0] count;
  logic          overflow;

  vram_write_queue_m #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk_12_5875  (clk),
    .rst          (rst),
    .cpu_wr_valid (valid),
    .cpu_wr_ready (cpu_wr_ready),
    .cpu_addr     (addr),
    .cpu_data     (data),
    .vblank       (vblank),
    .gpu_wr_en    (gpu_wr_en),
    .gpu_address  (gpu_address),
    .gpu_data     (gpu_data),
    .count        (count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  // Reference model: queue contents, drain mode, sticky overflow, expected GPU write.
  wr_t m_q[$];
  bit  m_drain;
  bit  m_ovf;
  bit  m_en;
  wr_t m_out;

  int checks = 0;
  int errors = 0;
  int n_wr   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rd();
    return 8'($urandom);
  endfunction

  task automatic step(input bit v, input logic [AW-1:0] av, input logic [7:0] dv, input bit vb);
    int sz;
    bit acc;
    bit pp;
    bit coal;
    valid  = v;
    addr   = av;
    data   = dv;
    vblank = vb;
    sz   = m_q.size();
    acc  = v && (sz != DEPTH);
    pp   = m_drain && vb && (sz != 0);
    coal = 1'b0;
`ifdef VRAM_WQ_COALESCE_EN
    coal = acc && (sz != 0) && (m_q[sz-1].a == av) && !(pp && sz == 1);
`endif
    if (v && !acc) m_ovf = 1'b1;
    m_en = pp;
    if (pp) m_out = m_q.pop_front();
    if (coal) m_q[m_q.size()-1].d = dv;
    else if (acc) m_q.push_back(wr_t'{a: av, d: dv});
    if (!m_drain) m_drain = vb && (sz != 0);
    else if (!vb || m_q.size() == 0) m_drain = 1'b0;

    @(posedge clk);
    #1;
    check("count", 32'(count), m_q.size());
    check("ready", 32'(cpu_wr_ready), 32'(m_q.size() != DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("wr_en", 32'(gpu_wr_en), 32'(m_en));
    if (m_en) begin
      check("gpu_address", 32'(gpu_address), 32'(m_out.a));
      check("gpu_data", 32'(gpu_data), 32'(m_out.d));
    end
    if (gpu_wr_en) n_wr++;
  endtask

  task automatic idle(input bit vb);
    step(1'b0, '0, '0, vb);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    valid  = 1'b1;
    vblank = 1'b1;
    addr   = 12'h3c5;
    data   = 8'h5a;
    #2;
    check("rst_count", 32'(count), 0);
    check("rst_wr_en", 32'(gpu_wr_en), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_ready", 32'(cpu_wr_ready), 1);
    check("rst_gpu_address", 32'(gpu_address), 0);
    check("rst_gpu_data", 32'(gpu_data), 0);
    @(posedge clk);
    #1;
    check("rst_hold_count", 32'(count), 0);
    check("rst_hold_wr_en", 32'(gpu_wr_en), 0);
    @(posedge clk);
    #3;
    rst    = 1'b0;
    valid  = 1'b0;
    vblank = 1'b0;
    m_q.delete();
    m_drain = 1'b0;
    m_ovf   = 1'b0;
    m_en    = 1'b0;
  endtask

  initial begin
    bit vb_r;
    rst    = 1'b0;
    valid  = 1'b0;
    vblank = 1'b0;
    addr   = '0;
    data   = '0;
    #1;
    do_reset();

    // Gating: nothing leaves outside vblank, then three strobes in order.
    n_wr = 0;
    step(1'b1, 12'h010, 8'hAA, 1'b0);
    step(1'b1, 12'h011, 8'hBB, 1'b0);
    step(1'b1, 12'h012, 8'hCC, 1'b0);
    repeat (3) idle(1'b0);
    check("gate_none", n_wr, 0);
    repeat (6) idle(1'b1);
    check("gate_three", n_wr, 3);

    // Full and overflow.
    for (int i = 0; i < 17; i++) step(1'b1, AW'(12'h040 + i), rd(), 1'b0);
    check("full_count", 32'(count), 16);
    check("full_ready", 32'(cpu_wr_ready), 0);
    check("full_ovf", 32'(overflow), 1);
    n_wr = 0;
    repeat (20) idle(1'b1);
    check("full_drain", n_wr, 16);

    // Reset mid-drain with five entries left.
    for (int i = 0; i < 7; i++) step(1'b1, AW'(12'h080 + i), rd(), 1'b0);
    repeat (3) idle(1'b1);
    check("pre_rst_count", 32'(count), 5);
    do_reset();
    n_wr = 0;
    repeat (6) idle(1'b1);
    check("post_rst_none", n_wr, 0);

    // Vblank cut after six cycles.
    for (int i = 0; i < 16; i++) step(1'b1, AW'(12'h0c0 + i), rd(), 1'b0);
    n_wr = 0;
    repeat (6) idle(1'b1);
    check("cut_writes", n_wr, 5);
    check("cut_count", 32'(count), 11);
    repeat (3) idle(1'b0);
    n_wr = 0;
    repeat (14) idle(1'b1);
    check("cut_rest", n_wr, 11);
    repeat (2) idle(1'b0);

    // Concurrent enqueue and drain at count 4.
    for (int i = 0; i < 5; i++) step(1'b1, AW'(12'h100 + i), rd(), 1'b0);
    idle(1'b1);
    idle(1'b1);
    check("conc_start", 32'(count), 4);
    n_wr = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, AW'(12'h200 + i), rd(), 1'b1);
      check("conc_count", 32'(count), 4);
    end
    repeat (6) idle(1'b1);
    check("conc_total", n_wr, 12);
    idle(1'b0);

    // Same-address pair.
    n_wr = 0;
    step(1'b1, 12'h020, 8'h11, 1'b0);
    step(1'b1, 12'h020, 8'h22, 1'b0);
    check("coal_count", 32'(count), ExpCoal);
    repeat (5) idle(1'b1);
    check("coal_writes", n_wr, ExpCoal);

    // Random traffic with a small address pool.
    vb_r = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) vb_r = ~vb_r;
      step(($urandom_range(0, 1) == 1), AW'($urandom_range(0, 3)), rd(), vb_r);
    end
    repeat (20) idle(1'b1);
    check("final_empty", 32'(count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
